// File: rtl/wb_target_sequencer.sv
// wb_target_sequencer
//   Registered Wishbone request sequencer sitting between the host port and
//   the downstream targets (GPIO ctl, LA ctl, team designs 1..NUM_TEAMS).
//   Each accepted host cycle produces exactly one target strobe, waits for
//   the selected target's ack and returns a single-cycle host ack. Unmapped
//   selects complete immediately with ERR_DATA. A watchdog, built only when
//   WB_SEQ_TIMEOUT_EN is defined, forces an error completion on a hung target.
//
// Ports
//   wb_clk_i       clock
//   wb_rst_i       synchronous active-high reset
//   wbs_cyc_i      host cycle
//   wbs_stb_i      host strobe
//   wbs_adr_i      host address; select field at [SEL_LSB +: SEL_WIDTH]
//   wbs_ack_o      host ack, one-cycle pulse
//   wbs_dat_o      host read data, valid with wbs_ack_o
//   tgt_stb_o      one-hot target strobe (0 GPIO, 1 LA, k+1 team k)
//   adr_truncated  {16'b0, latched wbs_adr_i[15:0]}
//   tgt_ack_i      target acks
//   tgt_dat_i      target read data, target i at [32*i +: 32]
//   busy_o         high while not IDLE
//   timeout_o      one-cycle pulse on watchdog completion (0 without the macro)
//
// Configuration macro: WB_SEQ_TIMEOUT_EN
//
// State table
//   state | meaning
//   IDLE  | waiting for host cyc&stb
//   BUSY  | strobing the selected target, waiting for its ack
//   ACK   | host ack cycle; request acceptance blocked for this cycle

module wb_target_sequencer #(
  parameter int          NUM_TEAMS      = 1,
  parameter int          SEL_LSB        = 16,
  parameter int          SEL_WIDTH      = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hBADD_A7A0,
  localparam int         N_TGT          = NUM_TEAMS + 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic [31:0]          wbs_adr_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [N_TGT-1:0]     tgt_stb_o,
  output logic [31:0]          adr_truncated,
  input  logic [N_TGT-1:0]     tgt_ack_i,
  input  logic [32*N_TGT-1:0]  tgt_dat_i,
  output logic                 busy_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e                 state_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic [15:0]            adr_q;
  logic                   ack_q;
  logic [31:0]            dat_q;
  logic [N_TGT-1:0]       stb_q;
  logic                   busy_q;

  logic [SEL_WIDTH-1:0]   sel_in;
  logic                   sel_in_mapped;
  logic [N_TGT-1:0]       stb_onehot;
  logic                   ack_hit;
  logic [31:0]            dat_hit;
  logic                   unused_adr_parity;

  assign sel_in = wbs_adr_i[SEL_LSB +: SEL_WIDTH];
  // Compare one bit wider so N_TGT == 2**SEL_WIDTH does not wrap to zero.
  assign sel_in_mapped = ({1'b0, sel_in} < (SEL_WIDTH+1)'(N_TGT));
  // Address bits outside the select and low-16 fields are intentionally ignored.
  assign unused_adr_parity = ^wbs_adr_i;

  // Decode the incoming select into a strobe, and the latched select into
  // the ack/data mux. Loop form avoids indexing with an over-wide select.
  always_comb begin
    stb_onehot = '0;
    ack_hit    = 1'b0;
    dat_hit    = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (sel_in == SEL_WIDTH'(i)) stb_onehot[i] = 1'b1;
      if (sel_q == SEL_WIDTH'(i)) begin
        ack_hit = tgt_ack_i[i];
        dat_hit = tgt_dat_i[32*i +: 32];
      end
    end
  end

`ifdef WB_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      adr_q     <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      stb_q     <= '0;
      busy_q    <= 1'b0;
`ifdef WB_SEQ_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            sel_q  <= sel_in;
            adr_q  <= wbs_adr_i[15:0];
            busy_q <= 1'b1;
            if (sel_in_mapped) begin
              state_q <= BUSY;
              stb_q   <= stb_onehot;
`ifdef WB_SEQ_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              // Unmapped target: complete at once without touching any target.
              state_q <= ACK;
              ack_q   <= 1'b1;
              dat_q   <= ERR_DATA;
            end
          end
        end
        BUSY: begin
          // Abort outranks ack: the host has left, so no ack may be returned.
          if (!wbs_cyc_i) begin
            state_q <= IDLE;
            stb_q   <= '0;
            busy_q  <= 1'b0;
`ifdef WB_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else if (ack_hit) begin
            state_q <= ACK;
            stb_q   <= '0;
            ack_q   <= 1'b1;
            dat_q   <= dat_hit;
          end
`ifdef WB_SEQ_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= ACK;
            stb_q     <= '0;
            ack_q     <= 1'b1;
            timeout_q <= 1'b1;
            dat_q     <= ERR_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
`ifdef WB_SEQ_TIMEOUT_EN
          timeout_q <= 1'b0;
          cnt_q     <= '0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign tgt_stb_o     = stb_q;
  assign adr_truncated = {16'b0, adr_q};
  assign busy_o        = busy_q;

endmodule
